// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). It replaces the fixed IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. in_ready comes straight from a flop, so
// out_ready has no combinational path back to in_ready.
//
// Ports:
//   Clk                      clock, rising edge
//   Clr                      synchronous active-high reset (priority over flush)
//   flush                    drop all held entries; same-cycle input discarded
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   in_data/in_ctrl/in_pc    incoming payload, control vector, NextPC tag
//   out_valid/out_ready      downstream handshake
//   out_data/out_ctrl/out_pc head entry; zero / NOP_CTRL when out_valid=0
//   stall_cnt                cycles with out_valid && !out_ready
//   bubble_cnt               cycles with !out_valid
//   flush_cnt                flushes taken
//
// Optional feature macro: PIPE_STAGE_PERF_EN enables the saturating
// performance counters. Without it the counter ports are tied to 0.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          CTRL_W   = 14,
    parameter int unsigned          PC_W     = 8,
    parameter logic [CTRL_W-1:0]    NOP_CTRL = '0,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [PC_W-1:0]   main_pc_q;

    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [PC_W-1:0]   skid_pc_q;

    logic accept;
    logic drain;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    // Main fields are forced to NOP/zero whenever main becomes empty, so the
    // outputs can be driven directly from the flops.
    always_ff @(posedge Clk) begin
        if (Clr || flush) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= NOP_CTRL;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= NOP_CTRL;
            skid_pc_q    <= '0;
        end else if (skid_valid_q) begin
            // Full: accept cannot happen; a drain promotes skid into main.
            if (drain) begin
                main_data_q  <= skid_data_q;
                main_ctrl_q  <= skid_ctrl_q;
                main_pc_q    <= skid_pc_q;
                skid_valid_q <= 1'b0;
            end
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_q <= 1'b1;
                main_data_q  <= in_data;
                main_ctrl_q  <= in_ctrl;
                main_pc_q    <= in_pc;
            end
        end else begin
            if (accept && drain) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
                main_pc_q   <= in_pc;
            end else if (accept) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= in_data;
                skid_ctrl_q  <= in_ctrl;
                skid_pc_q    <= in_pc;
            end else if (drain) begin
                main_valid_q <= 1'b0;
                main_data_q  <= '0;
                main_ctrl_q  <= NOP_CTRL;
                main_pc_q    <= '0;
            end
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_pc    = main_pc_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters; flush does not clear them.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!main_valid_q && bubble_cnt_q != '1) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
            if (flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 14;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CTRL_W-1:0] NOP = 14'h01A5;

    logic              Clk = 1'b0;
    logic              Clr;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    pipe_stage_skid #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .PC_W     (PC_W),
        .NOP_CTRL (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_pc     (out_pc),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = {24'h0, d};
        in_ctrl  = {6'h0, d};
        in_pc    = d ^ 8'hF0;
    endtask

    // Counter expectations depend on whether the feature is built in.
    function automatic logic [31:0] perf(input int v);
`ifdef PIPE_STAGE_PERF_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    initial begin
        Clr = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00);
        #1;

        // Reset
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_ctrl", 32'(out_ctrl), 32'(NOP));
        check("rst_out_data", out_data, 0);
        check("rst_out_pc", 32'(out_pc), 0);
        check("rst_stall", 32'(stall_cnt), 0);
        check("rst_bubble", 32'(bubble_cnt), 0);
        check("rst_flush", 32'(flush_cnt), 0);

        Clr = 1'b0;
        step();
        check("bubble_one", 32'(bubble_cnt), perf(1));

        // Streaming with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 8'h11);
        step();
        check("strm_a_valid", 32'(out_valid), 1);
        check("strm_a_data", out_data, 32'h11);
        check("strm_a_ctrl", 32'(out_ctrl), 32'h11);
        check("strm_a_pc", 32'(out_pc), 32'hE1);
        check("strm_a_rdy", 32'(in_ready), 1);
        drive(1'b1, 8'h22);
        step();
        check("strm_b_data", out_data, 32'h22);
        check("strm_b_rdy", 32'(in_ready), 1);
        drive(1'b1, 8'h33);
        step();
        check("strm_c_data", out_data, 32'h33);
        check("strm_c_pc", 32'(out_pc), 32'hC3);
        drive(1'b0, 8'h00);
        step();
        check("strm_empty_valid", 32'(out_valid), 0);
        check("strm_empty_ctrl", 32'(out_ctrl), 32'(NOP));
        check("strm_empty_data", out_data, 0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        drive(1'b1, 8'h11);
        step();
        check("bp_one_rdy", 32'(in_ready), 1);
        drive(1'b1, 8'h22);
        step();
        check("bp_full_rdy", 32'(in_ready), 0);
        check("bp_full_data", out_data, 32'h11);
        drive(1'b1, 8'h99);
        step();
        check("bp_hold_data", out_data, 32'h11);
        check("bp_hold_ctrl", 32'(out_ctrl), 32'h11);
        check("bp_hold_rdy", 32'(in_ready), 0);
        drive(1'b0, 8'h00);
        out_ready = 1'b1;
        step();
        check("bp_drain1_data", out_data, 32'h22);
        check("bp_drain1_pc", 32'(out_pc), 32'hD2);
        check("bp_drain1_rdy", 32'(in_ready), 1);
        step();
        check("bp_drain2_valid", 32'(out_valid), 0);

        // Flush at occupancy 2 with a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 8'h11);
        step();
        drive(1'b1, 8'h22);
        step();
        flush = 1'b1;
        drive(1'b1, 8'h44);
        #1;
        check("fl_cycle_rdy", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        check("fl_valid", 32'(out_valid), 0);
        check("fl_ctrl", 32'(out_ctrl), 32'(NOP));
        check("fl_data", out_data, 0);
        check("fl_rdy", 32'(in_ready), 1);
        check("fl_cnt", 32'(flush_cnt), perf(1));
        out_ready = 1'b1;
        step();
        check("fl_no44_valid", 32'(out_valid), 0);
        step();
        check("fl_no44_data", out_data, 0);

        // Flush at occupancy 0 also drops a same-cycle input
        flush = 1'b1;
        drive(1'b1, 8'h55);
        step();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        check("fl0_valid", 32'(out_valid), 0);
        check("fl0_cnt", 32'(flush_cnt), perf(2));

        // Clr together with flush, with an entry held
        out_ready = 1'b0;
        drive(1'b1, 8'h66);
        step();
        drive(1'b0, 8'h00);
        Clr = 1'b1;
        flush = 1'b1;
        step();
        Clr = 1'b0;
        flush = 1'b0;
        check("clrfl_valid", 32'(out_valid), 0);
        check("clrfl_ctrl", 32'(out_ctrl), 32'(NOP));
        check("clrfl_rdy", 32'(in_ready), 1);
        check("clrfl_flush", 32'(flush_cnt), 0);
        check("clrfl_stall", 32'(stall_cnt), 0);

        // Stall saturation
        drive(1'b1, 8'hAB);
        step();
        drive(1'b0, 8'h00);
        check("sat_bubble", 32'(bubble_cnt), perf(1));
        check("sat_stall0", 32'(stall_cnt), 0);
        for (int i = 0; i < 10; i++) step();
        check("sat_stall10", 32'(stall_cnt), perf(10));
        for (int i = 0; i < 10; i++) step();
        check("sat_stall15", 32'(stall_cnt), perf(15));
        check("sat_hold_data", out_data, 32'hAB);
        check("sat_bubble_hold", 32'(bubble_cnt), perf(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
